// File: rtl/booth_pkg.sv
// Shared types and constants for the booth5b sequencing front-end.
// The optional WAIT watchdog is enabled by defining BOOTH_FEEDER_TIMEOUT_EN.
package booth_pkg;

  localparam int BOOTH_W     = 5;
  localparam int PROD_W      = 10;
  localparam int TIMEOUT_DEF = 31;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SEND_X = 3'd2,
    SEND_Y = 3'd3,
    WAIT   = 3'd4,
    CAP_LO = 3'd5,
    OUT    = 3'd6
  } state_t;

endpackage

// File: rtl/booth_feeder_if.sv
// Operand, multiplier-side and result signals of booth_feeder bundled together.
// master = the feeder itself, slave = its environment; res_err exists only with BOOTH_FEEDER_TIMEOUT_EN.
interface booth_feeder_if;
  import booth_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [BOOTH_W-1:0]  in_x;
  logic [BOOTH_W-1:0]  in_y;
  logic                mul_start;
  logic [BOOTH_W-1:0]  mul_bus;
  logic [BOOTH_W-1:0]  mul_out;
  logic                mul_done;
  logic                res_valid;
  logic                res_ready;
  logic [PROD_W-1:0]   res_prod;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
  logic                res_err;
`endif

  modport master (
    input  in_valid, in_x, in_y, mul_out, mul_done, res_ready,
    output in_ready, mul_start, mul_bus, res_valid, res_prod
`ifdef BOOTH_FEEDER_TIMEOUT_EN
    , output res_err
`endif
  );

  modport slave (
    output in_valid, in_x, in_y, mul_out, mul_done, res_ready,
    input  in_ready, mul_start, mul_bus, res_valid, res_prod
`ifdef BOOTH_FEEDER_TIMEOUT_EN
    , input res_err
`endif
  );

endinterface

// File: rtl/booth_feeder_ctrl.sv
// Sequencing FSM for booth_feeder: all handshake outputs are registered, datapath strobes decode state.
// BOOTH_FEEDER_TIMEOUT_EN adds a 5-bit WAIT watchdog that aborts to OUT with res_err.
module booth_feeder_ctrl
  import booth_pkg::*;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
  #(parameter int TIMEOUT = TIMEOUT_DEF)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic mul_done,
  input  logic res_ready,
  output logic in_ready,
  output logic mul_start,
  output logic bus_x,
  output logic bus_y,
  output logic res_valid,
`ifdef BOOTH_FEEDER_TIMEOUT_EN
  output logic res_err,
  output logic clr_prod,
`endif
  output logic ld_ops,
  output logic cap_hi,
  output logic cap_lo
);

  state_t state;

`ifdef BOOTH_FEEDER_TIMEOUT_EN
  // Counter holds k during the (k+1)-th WAIT cycle, so the last allowed cycle sees TIMEOUT-1.
  localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

  logic [4:0] wait_cnt;
  logic       expire;

  assign expire   = (state == WAIT) && !mul_done && (wait_cnt == WAIT_LAST);
  assign clr_prod = expire;
`endif

  assign ld_ops = (state == IDLE) && in_valid;
  assign cap_hi = (state == WAIT) && mul_done;
  assign cap_lo = (state == CAP_LO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mul_start <= 1'b0;
      bus_x     <= 1'b0;
      bus_y     <= 1'b0;
      res_valid <= 1'b0;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
      res_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      mul_start <= 1'b0;
      bus_x     <= 1'b0;
      bus_y     <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= START;
            in_ready  <= 1'b0;
            mul_start <= 1'b1;
          end
        end
        START: begin
          state <= SEND_X;
          bus_x <= 1'b1;
        end
        SEND_X: begin
          state <= SEND_Y;
          bus_y <= 1'b1;
        end
        SEND_Y: begin
          state <= WAIT;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (mul_done) state <= CAP_LO;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 5'd1;
            if (expire) begin
              state     <= OUT;
              res_valid <= 1'b1;
              res_err   <= 1'b1;
            end
          end
`endif
        end
        CAP_LO: begin
          state     <= OUT;
          res_valid <= 1'b1;
        end
        OUT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
            res_err   <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/booth_feeder.sv
// Feeds a signed operand pair to booth5b over its shared 5-bit bus and reassembles the 10-bit product.
// Optional WAIT watchdog (TIMEOUT parameter, res_err) is built only with BOOTH_FEEDER_TIMEOUT_EN.
module booth_feeder
  import booth_pkg::*;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
  #(parameter int TIMEOUT = TIMEOUT_DEF)
`endif
(
  input  logic           clk,
  input  logic           rst,
  booth_feeder_if.master bus
);

  logic [BOOTH_W-1:0] x_q;
  logic [BOOTH_W-1:0] y_q;
  logic [PROD_W-1:0]  prod;
  logic               bus_x;
  logic               bus_y;
  logic               ld_ops;
  logic               cap_hi;
  logic               cap_lo;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
  logic               clr_prod;
`endif

`ifdef BOOTH_FEEDER_TIMEOUT_EN
  booth_feeder_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
`else
  booth_feeder_ctrl u_ctrl (
`endif
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .mul_done  (bus.mul_done),
    .res_ready (bus.res_ready),
    .in_ready  (bus.in_ready),
    .mul_start (bus.mul_start),
    .bus_x     (bus_x),
    .bus_y     (bus_y),
    .res_valid (bus.res_valid),
`ifdef BOOTH_FEEDER_TIMEOUT_EN
    .res_err   (bus.res_err),
    .clr_prod  (clr_prod),
`endif
    .ld_ops    (ld_ops),
    .cap_hi    (cap_hi),
    .cap_lo    (cap_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (ld_ops) begin
      x_q <= bus.in_x;
      y_q <= bus.in_y;
    end
  end

  // booth5b returns the high half on the done cycle and the low half one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
    end else if (clr_prod) begin
      prod <= '0;
`endif
    end else begin
      if (cap_hi) prod[PROD_W-1:BOOTH_W] <= bus.mul_out;
      if (cap_lo) prod[BOOTH_W-1:0]      <= bus.mul_out;
    end
  end

  assign bus.mul_bus  = bus_x ? x_q : (bus_y ? y_q : '0);
  assign bus.res_prod = prod;

endmodule

// File: tb/tb_booth_feeder.sv
// Self-checking bench for booth_feeder with a behavioural booth5b stand-in and arithmetic product model.
// Watchdog case runs only when BOOTH_FEEDER_TIMEOUT_EN is defined.
module tb_booth_feeder;

  logic clk = 1'b0;
  logic rst;

  booth_feeder_if bif ();

  booth_feeder dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_bad = 0;
  logic [9:0] last_prod;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] ref_mul(input logic [4:0] a, input logic [4:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[9:0];
  endfunction

  // Accept cycle through the first WAIT cycle; optional spurious done during SEND_X.
  task automatic front(input logic [4:0] x, input logic [4:0] y, input bit spur);
    bif.in_valid = 1'b1;
    bif.in_x     = x;
    bif.in_y     = y;
    chk("acc_rdy", bif.in_ready, 1);
    step();
    bif.in_valid = 1'b0;
    bif.in_x     = 5'($urandom);
    bif.in_y     = 5'($urandom);
    chk("start", bif.mul_start, 1);
    chk("start_bus", bif.mul_bus, 0);
    chk("busy_rdy", bif.in_ready, 0);
    step();
    chk("start_pulse", bif.mul_start, 0);
    chk("bus_x", bif.mul_bus, x);
    if (spur) begin
      bif.mul_done = 1'b1;
      bif.mul_out  = ~last_prod[9:5];
    end
    step();
    bif.mul_done = 1'b0;
    bif.mul_out  = '0;
    chk("bus_y", bif.mul_bus, y);
    chk("no_cap", bif.res_prod, last_prod);
    step();
    chk("wait_bus", bif.mul_bus, 0);
    chk("wait_vld", bif.res_valid, 0);
  endtask

  // Multiplier stand-in: done after lat extra WAIT cycles, high half then low half.
  task automatic back(input logic [4:0] x, input logic [4:0] y, input int lat, input bit hold);
    logic [9:0] p;
    p = ref_mul(x, y);
    repeat (lat) step();
    bif.mul_done = 1'b1;
    bif.mul_out  = p[9:5];
    step();
    bif.mul_done = 1'b0;
    bif.mul_out  = p[4:0];
    chk("caplo_vld", bif.res_valid, 0);
    if (hold) bif.res_ready = 1'b0;
    step();
    bif.mul_out = '0;
    chk("out_vld", bif.res_valid, 1);
    chk("prod", bif.res_prod, p);
`ifdef BOOTH_FEEDER_TIMEOUT_EN
    chk("out_err", bif.res_err, 0);
`endif
    last_prod = p;
  endtask

  task automatic out_hs();
    bif.res_ready = 1'b1;
    step();
    chk("hs_rdy", bif.in_ready, 1);
    chk("hs_vld", bif.res_valid, 0);
    chk("hs_hold", bif.res_prod, last_prod);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, bif.in_ready, 1);
    chk({tag, "_start"}, bif.mul_start, 0);
    chk({tag, "_bus"}, bif.mul_bus, 0);
    chk({tag, "_vld"}, bif.res_valid, 0);
    chk({tag, "_prod"}, bif.res_prod, 0);
`ifdef BOOTH_FEEDER_TIMEOUT_EN
    chk({tag, "_err"}, bif.res_err, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [4:0] rx;
    logic [4:0] ry;
    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in_x      = '0;
    bif.in_y      = '0;
    bif.mul_out   = '0;
    bif.mul_done  = 1'b0;
    bif.res_ready = 1'b1;
    last_prod     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;
    step();

    // 3 * -2 with a two-cycle multiplier latency
    front(5'h03, 5'h1E, 1'b0);
    back(5'h03, 5'h1E, 2, 1'b0);
    out_hs();

    // -16 * -16, done in the very first WAIT cycle, spurious done in SEND_X
    front(5'h10, 5'h10, 1'b1);
    back(5'h10, 5'h10, 0, 1'b0);
    out_hs();

    // 15 * -16 held in OUT for 10 cycles while the next pair waits upstream
    front(5'h0F, 5'h10, 1'b0);
    back(5'h0F, 5'h10, 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bif.in_valid = 1'b1;
      bif.in_x     = 5'h07;
      bif.in_y     = 5'h05;
      step();
      chk("hold_vld", bif.res_valid, 1);
      chk("hold_prod", bif.res_prod, 10'h310);
      chk("hold_rdy", bif.in_ready, 0);
    end
    out_hs();
    front(5'h07, 5'h05, 1'b0);
    back(5'h07, 5'h05, 3, 1'b0);
    out_hs();

    // spurious done while idle
    bif.mul_done = 1'b1;
    bif.mul_out  = ~last_prod[9:5];
    repeat (2) step();
    chk("idle_rdy", bif.in_ready, 1);
    chk("idle_vld", bif.res_valid, 0);
    chk("idle_prod", bif.res_prod, last_prod);
    bif.mul_done = 1'b0;
    bif.mul_out  = '0;

    // asynchronous reset in the middle of WAIT
    front(5'h09, 5'h0B, 1'b0);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    last_prod = '0;
    @(negedge clk);
    rst = 1'b0;
    step();
    front(5'h02, 5'h02, 1'b0);
    back(5'h02, 5'h02, 3, 1'b0);
    chk("two_sq", bif.res_prod, 10'h004);
    out_hs();

    for (int i = 0; i < 24; i++) begin
      rx = 5'($urandom);
      ry = 5'($urandom);
      front(rx, ry, 1'($urandom_range(0, 1)));
      back(rx, ry, $urandom_range(0, 5), 1'b0);
      out_hs();
    end

`ifdef BOOTH_FEEDER_TIMEOUT_EN
    front(5'h05, 5'h06, 1'b0);
    repeat (30) step();
    chk("to_pre_vld", bif.res_valid, 0);
    step();
    chk("to_vld", bif.res_valid, 1);
    chk("to_err", bif.res_err, 1);
    chk("to_prod", bif.res_prod, 0);
    last_prod = '0;
    out_hs();
    chk("to_err_clr", bif.res_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
